// File: rtl/rvseed_defines.sv
// Shared rvseed definitions used by the data-memory responder.
// Provides the access-size encodings, the responder FSM state type, the
// latency counter width and a helper that decides whether an access size
// is incompatible with the low address bits.
package rvseed_defines;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam int DMEM_LAT_WIDTH = 4;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'b00,
    DMEM_ST_WAIT = 2'b01,
    DMEM_ST_RESP = 2'b10
  } dmem_state_e;

  // True when size is illegal or the offset breaks natural alignment.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    f = 1'b0;
    case (size)
      MEM_SIZE_B: f = 1'b0;
      MEM_SIZE_H: f = off[0];
      MEM_SIZE_W: f = (off != 2'b00);
      default:    f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dmem_resp_lane.sv
// Combinational lane decode for the data-memory responder.
// Ports:
//   addr  - request byte address
//   size  - access size (byte/half/word/illegal)
//   wdata - right-aligned store data
//   be    - byte enables for the addressed word
//   wword - store data replicated onto every lane it may land in
//   fault - illegal size, misalignment or address outside the array
module dmem_resp_lane
  import rvseed_defines::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  input  logic [31:0]           wdata,
  output logic [3:0]            be,
  output logic [31:0]           wword,
  output logic                  fault
);

  logic out_of_range;

  // Any address bit above the word index makes the access out of range.
  if (ADDR_WIDTH > IDX_WIDTH + 2) begin : g_range
    assign out_of_range = |addr[ADDR_WIDTH-1:IDX_WIDTH+2];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (size)
      MEM_SIZE_B: begin
        be    = 4'b0001 << addr[1:0];
        wword = {4{wdata[7:0]}};
      end
      MEM_SIZE_H: begin
        be    = 4'b0011 << addr[1:0];
        wword = {2{wdata[15:0]}};
      end
      MEM_SIZE_W: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = wdata;
      end
    endcase
  end

  assign fault = size_fault(size, addr[1:0]) | out_of_range;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the rvseed load/store port.
// One request at a time; the response appears a fixed LATENCY (1..15)
// cycles after the accept edge. The array is read (and, for stores,
// lane-written) on the accept edge, so store responses carry the old word.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_we, req_addr, req_size, req_wdata - request payload
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata, rsp_err    - registered response payload
//   dbg_state             - current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the payload must be stable while valid is high and ready low.
module dmem_resp
  import rvseed_defines::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output dmem_state_e           dbg_state
);

  localparam int IDX_WIDTH = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_LAT_WIDTH-1:0] LAT_LOAD = DMEM_LAT_WIDTH'(LATENCY - 1);

  dmem_state_e               state;
  logic [DMEM_LAT_WIDTH-1:0] cnt;
  logic [31:0]               mem [DEPTH_WORDS];

  logic [IDX_WIDTH-1:0] idx;
  logic [3:0]           be;
  logic [31:0]          wword;
  logic                 fault;
  logic                 accept;

  dmem_resp_lane #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_lane (
    .addr (req_addr),
    .size (req_size),
    .wdata(req_wdata),
    .be   (be),
    .wword(wword),
    .fault(fault)
  );

  assign idx = req_addr[2 +: IDX_WIDTH];

  // Ready decodes the state register; it is also masked by rst so that no
  // request can slip in during the reset cycle.
  assign req_ready = (state == DMEM_ST_IDLE) && !rst;
  assign accept    = req_ready && req_valid;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DMEM_ST_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        DMEM_ST_IDLE: begin
          if (accept) begin
            rsp_rdata <= fault ? 32'h0 : mem[idx];
            rsp_err   <= fault;
            if (LATENCY == 1) begin
              state     <= DMEM_ST_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= DMEM_ST_WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end
        DMEM_ST_WAIT: begin
          // Entering RESP on count 1 makes rsp_valid visible LATENCY-1
          // edges after the accept edge.
          if (cnt == DMEM_LAT_WIDTH'(1)) begin
            state     <= DMEM_ST_RESP;
            rsp_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DMEM_ST_RESP: begin
          if (rsp_ready) begin
            state     <= DMEM_ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= DMEM_ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Array is never reset; a committed store survives a later reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

endmodule
